// File: rtl/msa_pkg.sv
// msa_pkg: shared constants and FSM state type for the multiplier-sharing arbiter.
package msa_pkg;

    localparam int OP_W   = 4;
    localparam int PROD_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        RESP
    } msa_state_t;

endpackage

// File: rtl/junsignedArrayMultiplier.sv
// junsignedArrayMultiplier: combinational unsigned OP_W x OP_W array multiplier.
module junsignedArrayMultiplier
    import msa_pkg::*;
(
    output logic [PROD_W-1:0] Y,
    input  logic [OP_W-1:0]   A,
    input  logic [OP_W-1:0]   B
);

    // One shifted partial-product row per multiplier bit, summed down the array.
    always_comb begin
        Y = '0;
        for (int unsigned i = 0; i < OP_W; i++) begin
            if (B[i]) begin
                Y = Y + (PROD_W'(A) << i);
            end
        end
    end

endmodule

// File: rtl/mult_share_arbiter.sv
// mult_share_arbiter: round-robin sharing of one array multiplier between two requesters.
// Optional per-requester saturating grant counters when MSA_STATS_EN is defined.
module mult_share_arbiter
    import msa_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [OP_W-1:0]   req0_a,
    input  logic [OP_W-1:0]   req0_b,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [OP_W-1:0]   req1_a,
    input  logic [OP_W-1:0]   req1_b,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [PROD_W-1:0] rsp_y,
    output logic              rsp_id
`ifdef MSA_STATS_EN
    ,
    output logic [CNT_W-1:0]  grant_cnt0,
    output logic [CNT_W-1:0]  grant_cnt1
`endif
);

    msa_state_t        state_q, state_d;
    logic              last_grant_q;
    logic [OP_W-1:0]   a_q, b_q;
    logic              id_q;
    logic [PROD_W-1:0] prod;
    logic              grant_any, grant_id, accept;

    junsignedArrayMultiplier u_mul (
        .Y (prod),
        .A (a_q),
        .B (b_q)
    );

    // On a tie the requester that was not granted last wins.
    always_comb begin
        grant_any = 1'b0;
        grant_id  = 1'b0;
        if (req0_valid && req1_valid) begin
            grant_any = 1'b1;
            grant_id  = ~last_grant_q;
        end else if (req0_valid) begin
            grant_any = 1'b1;
        end else if (req1_valid) begin
            grant_any = 1'b1;
            grant_id  = 1'b1;
        end
    end

    always_comb begin
        state_d    = state_q;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        rsp_valid  = 1'b0;
        case (state_q)
            IDLE: begin
                if (!rst && grant_any) begin
                    req0_ready = ~grant_id;
                    req1_ready = grant_id;
                    state_d    = MUL;
                end
            end
            MUL:  state_d = RESP;
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign accept = req0_ready | req1_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            a_q          <= '0;
            b_q          <= '0;
            id_q         <= 1'b0;
            rsp_y        <= '0;
            rsp_id       <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                a_q          <= grant_id ? req1_a : req0_a;
                b_q          <= grant_id ? req1_b : req0_b;
                id_q         <= grant_id;
                last_grant_q <= grant_id;
            end
            if (state_q == MUL) begin
                rsp_y  <= prod;
                rsp_id <= id_q;
            end
        end
    end

`ifdef MSA_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grant_cnt0 <= '0;
            grant_cnt1 <= '0;
        end else begin
            if (req0_ready && grant_cnt0 != '1) begin
                grant_cnt0 <= grant_cnt0 + CNT_W'(1);
            end
            if (req1_ready && grant_cnt1 != '1) begin
                grant_cnt1 <= grant_cnt1 + CNT_W'(1);
            end
        end
    end
`else
    logic [CNT_W-1:0] stats_unused;
    assign stats_unused = '0;
`endif

endmodule

// File: tb/tb_mult_share_arbiter.sv
// tb_mult_share_arbiter: scenario tasks plus randomized traffic checked against a
// transaction-timeline model of the arbiter (accept at N -> response from N+2 until taken).
module tb_mult_share_arbiter;

    localparam int CNT_W = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic       req0_valid, req0_ready, req1_valid, req1_ready;
    logic [3:0] req0_a, req0_b, req1_a, req1_b;
    logic       rsp_valid, rsp_ready, rsp_id;
    logic [7:0] rsp_y;
`ifdef MSA_STATS_EN
    logic [CNT_W-1:0] grant_cnt0, grant_cnt1;
`endif

    mult_share_arbiter #(.CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_y      (rsp_y),
        .rsp_id     (rsp_id)
`ifdef MSA_STATS_EN
        ,
        .grant_cnt0 (grant_cnt0),
        .grant_cnt1 (grant_cnt1)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    // Reference model: one outstanding transaction, described by when it was accepted.
    bit m_pending = 0;
    int m_acc     = 0;
    int m_y       = 0;
    bit m_id      = 0;
    bit m_last    = 1;
    int m_cnt0    = 0;
    int m_cnt1    = 0;
    bit e_r0, e_r1, e_rv;

    task automatic drive(input bit v0, input int a0, input int b0,
                         input bit v1, input int a1, input int b1, input bit rr);
        req0_valid = v0;
        req0_a     = 4'(a0);
        req0_b     = 4'(b0);
        req1_valid = v1;
        req1_a     = 4'(a1);
        req1_b     = 4'(b1);
        rsp_ready  = rr;
    endtask

    task automatic settle();
        @(negedge clk);
        e_r0 = 0;
        e_r1 = 0;
        e_rv = 0;
        if (rst) begin
            m_pending = 0;
            m_last    = 1;
            m_cnt0    = 0;
            m_cnt1    = 0;
        end else if (m_pending) begin
            e_rv = (cyc >= m_acc + 2);
        end else if (req0_valid && req1_valid) begin
            e_r0 = m_last;
            e_r1 = !m_last;
        end else begin
            e_r0 = req0_valid;
            e_r1 = req1_valid;
        end
    endtask

    task automatic commit();
        if (!rst) begin
            if (e_rv && rsp_ready) m_pending = 0;
            if (e_r0 && req0_valid) begin
                m_pending = 1; m_acc = cyc; m_id = 0; m_last = 0;
                m_y = int'(req0_a) * int'(req0_b);
                if (m_cnt0 < (1 << CNT_W) - 1) m_cnt0++;
            end else if (e_r1 && req1_valid) begin
                m_pending = 1; m_acc = cyc; m_id = 1; m_last = 1;
                m_y = int'(req1_a) * int'(req1_b);
                if (m_cnt1 < (1 << CNT_W) - 1) m_cnt1++;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int n);
        drive(0, 0, 0, 0, 0, 0, 1);
        repeat (n) begin
            settle();
            commit();
        end
    endtask

    task automatic pulse_reset();
        rst = 1;
        drive(0, 0, 0, 0, 0, 0, 1);
        settle();
        commit();
        rst = 0;
    endtask

    task automatic test_reset();
        rst = 1;
        drive(1, 1, 1, 1, 2, 2, 1);
        settle();
        checks++; if (req0_ready !== 1'b0) begin errors++; $display("FAIL reset_ready0 got=%b exp=0", req0_ready); end
        checks++; if (req1_ready !== 1'b0) begin errors++; $display("FAIL reset_ready1 got=%b exp=0", req1_ready); end
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
        checks++; if (rsp_y !== 8'd0) begin errors++; $display("FAIL reset_rsp_y got=%0d exp=0", rsp_y); end
        checks++; if (rsp_id !== 1'b0) begin errors++; $display("FAIL reset_rsp_id got=%b exp=0", rsp_id); end
        commit();
        rst = 0;
        drive(1, 3, 3, 0, 0, 0, 1);
        settle();
        checks++; if (req0_ready !== 1'b1) begin errors++; $display("FAIL reset_pre_accept got=%b exp=1", req0_ready); end
        commit();
        rst = 1;
        drive(1, 4, 4, 1, 5, 5, 1);
        settle();
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL abort_rsp_valid got=%b exp=0", rsp_valid); end
        checks++; if ({req0_ready, req1_ready} !== 2'b00) begin errors++; $display("FAIL abort_ready got=%b exp=00", {req0_ready, req1_ready}); end
        commit();
        rst = 0;
        drive(0, 0, 0, 0, 0, 0, 1);
        for (int k = 0; k < 3; k++) begin
            settle();
            checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL abort_no_rsp k=%0d got=%b exp=0", k, rsp_valid); end
            commit();
        end
        drive(1, 6, 6, 1, 7, 7, 1);
        settle();
        checks++; if ({req0_ready, req1_ready} !== 2'b10) begin errors++; $display("FAIL reset_tie_req0 got=%b exp=10", {req0_ready, req1_ready}); end
        commit();
        drain(4);
    endtask

    task automatic test_single();
        int n, first, y, id;
        first = -1; y = 0; id = 0;
        drive(1, 3, 5, 0, 0, 0, 1);
        settle();
        checks++; if (req0_ready !== 1'b1) begin errors++; $display("FAIL single_ready got=%b exp=1", req0_ready); end
        n = cyc;
        commit();
        drive(0, 0, 0, 0, 0, 0, 1);
        for (int k = 0; k < 6; k++) begin
            settle();
            if (rsp_valid === 1'b1 && first < 0) begin first = cyc; y = rsp_y; id = rsp_id; end
            commit();
        end
        checks++; if (first != n + 2) begin errors++; $display("FAIL single_latency got=%0d exp=%0d", first - n, 2); end
        checks++; if (y != 15) begin errors++; $display("FAIL single_y got=%0d exp=15", y); end
        checks++; if (id != 0) begin errors++; $display("FAIL single_id got=%0d exp=0", id); end
    endtask

    task automatic test_contention();
        int gq[$], yq[$], iq[$];
        int exp_g[3] = '{0, 1, 0};
        int exp_y[3] = '{0, 225, 0};
        pulse_reset();
        drive(1, 0, 0, 1, 15, 15, 1);
        for (int k = 0; k < 30 && (gq.size() < 3 || yq.size() < 3); k++) begin
            settle();
            if (req0_valid && req0_ready === 1'b1) gq.push_back(0);
            if (req1_valid && req1_ready === 1'b1) gq.push_back(1);
            if (rsp_valid === 1'b1 && rsp_ready) begin yq.push_back(int'(rsp_y)); iq.push_back(int'(rsp_id)); end
            commit();
        end
        drain(4);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (i >= gq.size() || gq[i] != exp_g[i]) begin
                errors++; $display("FAIL contention_grant i=%0d got=%0d exp=%0d", i, (i < gq.size()) ? gq[i] : -1, exp_g[i]);
            end
            checks++;
            if (i >= yq.size() || yq[i] != exp_y[i] || iq[i] != exp_g[i]) begin
                errors++; $display("FAIL contention_rsp i=%0d got_y=%0d got_id=%0d exp_y=%0d exp_id=%0d", i,
                    (i < yq.size()) ? yq[i] : -1, (i < iq.size()) ? iq[i] : -1, exp_y[i], exp_g[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        int stall = 0;
        pulse_reset();
        drive(1, 1, 1, 1, 1, 1, 0);
        for (int k = 0; k < 12 && stall < 5; k++) begin
            settle();
            if (rsp_valid === 1'b1) begin
                stall++;
                checks++; if (rsp_y !== 8'd1) begin errors++; $display("FAIL bp_hold_y got=%0d exp=1", rsp_y); end
                checks++; if ({req0_ready, req1_ready} !== 2'b00) begin errors++; $display("FAIL bp_no_ready got=%b exp=00", {req0_ready, req1_ready}); end
            end
            commit();
        end
        checks++; if (stall != 5) begin errors++; $display("FAIL bp_timeout got=%0d stall cycles exp=5", stall); end
        drive(1, 1, 1, 1, 1, 1, 1);
        settle();
        checks++; if (rsp_valid !== 1'b1 || rsp_y !== 8'd1) begin errors++; $display("FAIL bp_release got=%b/%0d exp=1/1", rsp_valid, rsp_y); end
        commit();
        settle();
        checks++; if ({req0_ready, req1_ready} !== 2'b01) begin errors++; $display("FAIL bp_resume got=%b exp=01", {req0_ready, req1_ready}); end
        commit();
        drain(4);
    endtask

    task automatic test_operand_change();
        bit got = 0;
        drive(0, 0, 0, 1, 7, 9, 1);
        settle();
        checks++; if (req1_ready !== 1'b1) begin errors++; $display("FAIL opchg_ready got=%b exp=1", req1_ready); end
        commit();
        drive(0, 0, 0, 1, 2, 2, 1);
        for (int k = 0; k < 5 && !got; k++) begin
            settle();
            if (rsp_valid === 1'b1) begin
                got = 1;
                checks++; if (rsp_y !== 8'd63) begin errors++; $display("FAIL opchg_y got=%0d exp=63", rsp_y); end
                checks++; if (rsp_id !== 1'b1) begin errors++; $display("FAIL opchg_id got=%b exp=1", rsp_id); end
            end
            commit();
        end
        checks++; if (!got) begin errors++; $display("FAIL opchg_timeout got=no rsp exp=rsp"); end
        drain(4);
    endtask

`ifdef MSA_STATS_EN
    task automatic test_stats();
        int acc = 0;
        pulse_reset();
        drive(1, 2, 2, 1, 3, 3, 1);
        for (int k = 0; k < 40 && acc < 5; k++) begin
            settle();
            if (req0_ready === 1'b1 || req1_ready === 1'b1) acc++;
            commit();
        end
        drain(4);
        checks++; if (grant_cnt0 !== 3'd3) begin errors++; $display("FAIL stats_cnt0 got=%0d exp=3", grant_cnt0); end
        checks++; if (grant_cnt1 !== 3'd2) begin errors++; $display("FAIL stats_cnt1 got=%0d exp=2", grant_cnt1); end
        drive(1, 2, 2, 1, 3, 3, 1);
        for (int k = 0; k < 120 && acc < 20; k++) begin
            settle();
            if (req0_ready === 1'b1 || req1_ready === 1'b1) acc++;
            commit();
        end
        drain(4);
        checks++; if (grant_cnt0 !== 3'd7) begin errors++; $display("FAIL stats_sat0 got=%0d exp=7", grant_cnt0); end
        checks++; if (grant_cnt1 !== 3'd7) begin errors++; $display("FAIL stats_sat1 got=%0d exp=7", grant_cnt1); end
    endtask
`endif

    task automatic test_random(input int n);
        pulse_reset();
        for (int i = 0; i < n; i++) begin
            drive($urandom_range(0, 1), $urandom_range(0, 15), $urandom_range(0, 15),
                  $urandom_range(0, 1), $urandom_range(0, 15), $urandom_range(0, 15),
                  $urandom_range(0, 3) != 0);
            settle();
            checks++; if (req0_ready !== e_r0) begin errors++; $display("FAIL rand_ready0 cyc=%0d got=%b exp=%b", cyc, req0_ready, e_r0); end
            checks++; if (req1_ready !== e_r1) begin errors++; $display("FAIL rand_ready1 cyc=%0d got=%b exp=%b", cyc, req1_ready, e_r1); end
            checks++; if (rsp_valid !== e_rv) begin errors++; $display("FAIL rand_rsp_valid cyc=%0d got=%b exp=%b", cyc, rsp_valid, e_rv); end
            if (e_rv) begin
                checks++; if (rsp_y !== 8'(m_y)) begin errors++; $display("FAIL rand_rsp_y cyc=%0d got=%0d exp=%0d", cyc, rsp_y, m_y); end
                checks++; if (rsp_id !== m_id) begin errors++; $display("FAIL rand_rsp_id cyc=%0d got=%b exp=%b", cyc, rsp_id, m_id); end
            end
`ifdef MSA_STATS_EN
            checks++; if (int'(grant_cnt0) != m_cnt0 || int'(grant_cnt1) != m_cnt1) begin
                errors++; $display("FAIL rand_cnt cyc=%0d got=%0d/%0d exp=%0d/%0d", cyc, grant_cnt0, grant_cnt1, m_cnt0, m_cnt1);
            end
`endif
            commit();
        end
        drain(4);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1;
        drive(0, 0, 0, 0, 0, 0, 1);
        @(posedge clk);
        #1;
        test_reset();
        test_single();
        test_contention();
        test_backpressure();
        test_operand_change();
`ifdef MSA_STATS_EN
        test_stats();
`endif
        test_random(400);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mult_share_arbiter.md
MULT_SHARE_ARBITER -- requirements
Module: mult_share_arbiter

Interface
REQ-001 Parameter: CNT_W, 16, width of per-requester grant counters (used only with MSA_STATS_EN).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 req0_valid  input  1  requester 0 has operands.
REQ-005 req0_ready  output 1  requester 0 operands accepted this cycle.
REQ-006 req0_a, req0_b  input  4 each  requester 0 unsigned operands.
REQ-007 req1_valid, req1_ready, req1_a, req1_b: same as REQ-004..006 for requester 1.
REQ-008 rsp_valid  output 1  product available.
REQ-009 rsp_ready  input  1  consumer accepts product.
REQ-010 rsp_y  output 8  unsigned product a*b.
REQ-011 rsp_id  output 1  requester index that owns rsp_y.
REQ-012 grant_cnt0, grant_cnt1  output CNT_W each  accepted-transaction counts (MSA_STATS_EN only).

Function
REQ-013 FSM states: IDLE, MUL, RESP; one transaction in flight at a time.
REQ-014 IDLE: reqN_ready SHALL be combinationally 1 only for the granted requester; the other ready is 0.
REQ-015 Grant: only one valid -> that one; both valid -> requester other than last_grant (round-robin); none valid -> no ready asserted.
REQ-016 Accept (valid & ready in IDLE): latch a, b, id; update last_grant; next state MUL.
REQ-017 MUL: product of latched operands SHALL be registered into rsp_y; rsp_id set; next state RESP.
REQ-018 RESP: rsp_valid=1; rsp_y/rsp_id held stable until rsp_ready=1; on rsp_ready -> IDLE.
REQ-019 Latency: accept in cycle N -> rsp_valid first high in cycle N+2; min spacing between accepts 3 cycles.
REQ-020 Both reqN_ready SHALL be 0 in MUL and RESP, regardless of valid inputs.
REQ-021 Arithmetic: rsp_y = a*b exactly, 8-bit, no overflow possible (max 15*15=225).
REQ-022 Requester dropping valid before acceptance SHALL lose nothing and change no state.
REQ-023 Operand inputs changing after acceptance SHALL NOT affect the in-flight product.

Reset
REQ-024 On rst: state=IDLE, rsp_valid=0, rsp_y=0, rsp_id=0, latched operands=0, last_grant=1 (requester 0 wins first tie), counters=0.
REQ-025 rst asserted mid-transaction SHALL abort it; no rsp_valid after deassertion for that transaction.
REQ-026 While rst high, req0_ready=req1_ready=0.

Configuration
REQ-027 Macro MSA_STATS_EN defined: grant_cnt0/1 present; increment by 1 on each accept of that requester; saturate at all-ones.
REQ-028 MSA_STATS_EN undefined: grant_cnt0/1 ports and counters absent; all other behaviour identical.

Structure
REQ-029 Shared package msa_pkg: state enum (IDLE, MUL, RESP), OP_W=4, PROD_W=8 constants.
REQ-030 One sub-module: existing junsignedArrayMultiplier (Y, A, B) instantiated on latched operands; no other multiplier logic.

Verification
REQ-031 Reset: rst=1 mid-MUL -> next cycles rsp_valid=0, both ready=0; after release, req0 ties win first.
REQ-032 Single request: req0 a=3,b=5 accepted cycle N -> rsp_valid cycle N+2, rsp_y=15, rsp_id=0.
REQ-033 Contention: both valid continuously (req0 0*0, req1 15*15) -> grants alternate 0,1,0; rsp_y 0,225,0; ids 0,1,0.
REQ-034 Backpressure: rsp_ready=0 for 5 cycles with 1*1 pending -> rsp_y=1 held, no ready asserted; accept resumes 1 cycle after rsp_ready.
REQ-035 Operand change: req1 a=7,b=9 accepted, then inputs switch to 2,2 -> rsp_y=63.
REQ-036 Stats (MSA_STATS_EN): 3 req0 and 2 req1 accepts -> grant_cnt0=3, grant_cnt1=2; forced near max -> saturates at all-ones.
